alu_mult_seq_unit: RTL and testbench

Sequential responder for the 32-bit ALU-with-multiplier operation interface. It accepts one operation request (`alu_op`, `a`, `b`) through a start/busy handshake, computes single-cycle ops in one clock and multiplication via a 32-iteration shift-add datapath, then returns a registered result with a one-cycle `done` strobe. It sits between an issuing controller (or bench) and the register write-back path.

---
 rtl/alu_mult_seq_unit.sv | 136 +++++++++++++
 tb/tb_alu_mult_seq_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_seq_unit.sv
// rtl/alu_mult_seq_unit.sv - sequential ALU with 32-iteration shift-add multiplier
// Optional feature macro: ALU_MULT_HI_EN (adds res_hi, the product upper half)
module alu_mult_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
`ifdef ALU_MULT_HI_EN
  output logic [WIDTH-1:0] res_hi,
`endif
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MULT = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_next;
  logic [WIDTH:0]     upper_sum;
  logic [WIDTH-1:0]   alu_res;

  // single-cycle ops evaluated straight from the incoming operands
  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:  alu_res = a + b;
      OP_XOR:  alu_res = a ^ b;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR:  alu_res = ~(a | b);
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      default: alu_res = '0;
    endcase
  end

  // one shift-add step: conditional add into the upper half keeping the carry, then shift right
  always_comb begin
    upper_sum = {1'b0, product[2*WIDTH-1:WIDTH]};
    if (product[0]) begin
      upper_sum = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end
    product_next = {upper_sum, product[WIDTH-1:1]};
  end

  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      res     <= '0;
      zero    <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      product <= '0;
`ifdef ALU_MULT_HI_EN
      res_hi  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (alu_op == OP_MULT) begin
              mcand   <= a;
              product <= {{WIDTH{1'b0}}, b};
              cnt     <= '0;
              state   <= MULT;
            end else begin
              res    <= alu_res;
              zero   <= (alu_res == '0);
`ifdef ALU_MULT_HI_EN
              res_hi <= '0;
`endif
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        MULT: begin
          product <= product_next;
          if (cnt == LAST_ITER) begin
            cnt    <= '0;
            res    <= product_next[WIDTH-1:0];
            zero   <= (product_next[WIDTH-1:0] == '0);
`ifdef ALU_MULT_HI_EN
            res_hi <= product_next[2*WIDTH-1:WIDTH];
`endif
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_seq_unit.sv
// tb/tb_alu_mult_seq_unit.sv - scoreboard bench for alu_mult_seq_unit
module tb_alu_mult_seq_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   alu_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic         zero;
`ifdef ALU_MULT_HI_EN
  logic [W-1:0] res_hi;
`endif

  int total = 0;
  int bad = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  alu_mult_seq_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .alu_op(alu_op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .res(res),
`ifdef ALU_MULT_HI_EN
    .res_hi(res_hi),
`endif
    .zero(zero)
  );

  // reference model: {hi, lo}; hi is zero except for mult
  function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    logic [2*W-1:0] xe;
    logic [2*W-1:0] ye;
    r = '0;
    xe = {{W{1'b0}}, x};
    ye = {{W{1'b0}}, y};
    case (op)
      3'd0: r = x + y;
      3'd1: r = x ^ y;
      3'd2: r = x - y;
      3'd3: return xe * ye;
      3'd4: r = ($signed(x) < $signed(y)) ? 1 : 0;
      3'd5: r = ~(x | y);
      3'd6: r = x & y;
      default: r = x | y;
    endcase
    return {{W{1'b0}}, r};
  endfunction

  function automatic logic hi_of(input int dummy);
    return 1'b0 | dummy[0];
  endfunction

  // issue one request from idle, wait (bounded) for done, return observations, settle back to idle
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output logic z, output logic [W-1:0] rh, output int cyc);
    start = 1'b1; alu_op = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    r = res; z = zero;
`ifdef ALU_MULT_HI_EN
    rh = res_hi;
`else
    rh = '0;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; alu_op = 3'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (res !== '0) begin bad++; $display("FAIL reset_res got=%h want=0", res); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", zero); end
`ifdef ALU_MULT_HI_EN
    total++; if (res_hi !== '0) begin bad++; $display("FAIL reset_res_hi got=%h want=0", res_hi); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // push expected, run, pop and compare result, zero, hi and latency in cycles
  task automatic check_op(input string name, input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    logic [W-1:0] rh;
    logic z;
    int cyc;
    logic [2*W-1:0] e;
    int want_cyc;
    exp_q.push_back(model(op, x, y));
    want_cyc = (op == 3'd3) ? W + 1 : 1;
    run_op(op, x, y, r, z, rh, cyc);
    e = exp_q.pop_front();
    total++; if (cyc !== want_cyc) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, want_cyc); end
    total++; if (r !== e[W-1:0]) begin bad++; $display("FAIL %s_res got=%h want=%h", name, r, e[W-1:0]); end
    total++; if (z !== (e[W-1:0] == '0)) begin bad++; $display("FAIL %s_zero got=%b want=%b", name, z, (e[W-1:0] == '0)); end
`ifdef ALU_MULT_HI_EN
    total++; if (rh !== e[2*W-1:W]) begin bad++; $display("FAIL %s_res_hi got=%h want=%h", name, rh, e[2*W-1:W]); end
`else
    if (rh !== '0) $display("note %s unexpected hi", name);
`endif
  endtask

  task automatic test_mult;
    check_op("mult_15x3", 3'd3, 32'd15, 32'd3);
    check_op("mult_mixed", 3'd3, 32'h1234_5678, 32'h9ABC_DEF1);
    check_op("mult_zero", 3'd3, 32'h0000_0000, 32'hDEAD_BEEF);
  endtask

  task automatic test_single_ops;
    check_op("add", 3'd0, 32'd13, 32'd12);
    check_op("sub", 3'd2, 32'h8000_000D, 32'h8000_000F);
    check_op("xor", 3'd1, 32'h0200_000D, 32'h0200_000C);
    check_op("and_zero", 3'd6, 32'hA5A5_0F0F, 32'h5A5A_F0F0);
  endtask

  task automatic test_slt_nor_or;
    check_op("slt_lt", 3'd4, 32'h0200_000D, 32'h2200_000C);
    check_op("slt_ge", 3'd4, 32'h0200_000D, 32'h0200_000C);
    check_op("slt_neg", 3'd4, 32'h8000_0000, 32'h0000_0001);
    check_op("nor", 3'd5, 32'h0200_000D, 32'h0200_000C);
    check_op("or", 3'd7, 32'h0200_000D, 32'h0200_000C);
  endtask

  task automatic test_max_mult;
    check_op("mult_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_ignore_start;
    int ndone;
    logic [W-1:0] got;
    logic [2*W-1:0] e;
    ndone = 0; got = '0;
    exp_q.push_back(model(3'd3, 32'd7, 32'd9));
    start = 1'b1; alu_op = 3'd3; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hFFFF_0000; b = 32'h0000_FFFF;
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) begin start = 1'b1; alu_op = 3'd0; a = 32'd1; b = 32'd1; end
      if (k == 11) start = 1'b0;
      @(posedge clk); #1;
      if (done === 1'b1) begin ndone++; got = res; end
    end
    e = exp_q.pop_front();
    total++; if (ndone !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", ndone); end
    total++; if (got !== e[W-1:0]) begin bad++; $display("FAIL ignore_res got=%h want=%h", got, e[W-1:0]); end
  endtask

  task automatic test_back_to_back;
    int ndone;
    int last_k;
    logic [2*W-1:0] e;
    ndone = 0; last_k = -1;
    for (int k = 0; k < 12; k++) begin
      start = 1'b1; alu_op = 3'd0; a = 32'(k * 7 + 1); b = 32'(k * 3 + 100);
      if (busy === 1'b0) exp_q.push_back(model(3'd0, a, b));
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL b2b_unexpected_done got=1 want=0");
        end else begin
          e = exp_q.pop_front();
          total++; if (res !== e[W-1:0]) begin bad++; $display("FAIL b2b_res got=%h want=%h", res, e[W-1:0]); end
        end
        if (last_k >= 0) begin
          total++; if (k - last_k !== 2) begin bad++; $display("FAIL b2b_spacing got=%0d want=2", k - last_k); end
        end
        last_k = k;
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    total++; if (ndone !== 6) begin bad++; $display("FAIL b2b_done_count got=%0d want=6", ndone); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_leftover got=%0d want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    int ndone;
    ndone = 0;
    start = 1'b1; alu_op = 3'd3; a = 32'h0001_2345; b = 32'h0000_6789;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", done); end
    total++; if (res !== '0) begin bad++; $display("FAIL rstmid_res got=%h want=0", res); end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL rstmid_stray_done got=%0d want=0", ndone); end
    check_op("add_after_rst", 3'd0, 32'd2, 32'd3);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_single_ops();
    test_slt_nor_or();
    test_max_mult();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
